// File: rtl/pc_return_stack.sv
`default_nettype none
// ============================================================================
// pc_return_stack : program counter with next-PC select and return stack
// Optional PC_STACK_TRAP_EN: JSR on a full stack traps to TRAP_VEC
// instead of overwriting the oldest entry.  Rev 1.0
// ============================================================================
module pc_return_stack #(
  parameter int              AW       = 10,
  parameter int              OW       = 8,
  parameter int              DEPTH    = 4,
  parameter logic [AW-1:0]   TRAP_VEC = '1,
  localparam int             SPW      = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              hold,
  input  logic [2:0]        op,
  input  logic              cz,
  input  logic              csel,
  input  logic [AW-1:0]     start_address,
  input  logic [AW-1:0]     br_tgt,
  input  logic [AW-1:0]     subroutine,
  input  logic [OW-1:0]     rv,
  input  logic [AW-OW-1:0]  page,
  output logic [AW-1:0]     rp,
  output logic [AW-1:0]     npc,
  output logic [SPW-1:0]    sp,
  output logic              full,
  output logic              empty,
  output logic              err
);

  localparam logic [2:0] OP_BR  = 3'd1;
  localparam logic [2:0] OP_REL = 3'd2;
  localparam logic [2:0] OP_JSR = 3'd3;
  localparam logic [2:0] OP_RET = 3'd4;
  localparam logic [2:0] OP_LJ  = 3'd5;

  logic [AW-1:0] stack [DEPTH];
  logic [AW-1:0] w_inc;
  logic [AW-1:0] w_rel;
  logic [AW-1:0] w_top;
  logic          w_taken;
  logic          w_push;
  logic          w_pop;
  logic          w_shift;
  logic          w_err;

  assign full  = (sp == SPW'(DEPTH));
  assign empty = (sp == '0);

  assign w_inc   = rp + AW'(1);
  assign w_rel   = rp + {{(AW-OW){rv[OW-1]}}, rv};
  assign w_taken = (cz == csel);

  always_comb begin
    w_top = '0;
    for (int i = 0; i < DEPTH; i++)
      if (sp == SPW'(i + 1)) w_top = stack[i];
  end

  always_comb begin
    npc     = w_inc;
    w_push  = 1'b0;
    w_pop   = 1'b0;
    w_shift = 1'b0;
    w_err   = 1'b0;
    if (start) begin
      npc = start_address;
    end else if (hold) begin
      npc = rp;
    end else begin
      case (op)
        OP_BR:  if (w_taken) npc = br_tgt;
        OP_REL: if (w_taken) npc = w_rel;
        OP_JSR: begin
          if (!full) begin
            npc    = subroutine;
            w_push = 1'b1;
          end else begin
            w_err = 1'b1;
`ifdef PC_STACK_TRAP_EN
            npc = TRAP_VEC;
`else
            npc     = subroutine;
            w_shift = 1'b1;
`endif
          end
        end
        OP_RET: begin
          if (!empty) begin
            npc   = w_top;
            w_pop = 1'b1;
          end else begin
            w_err = 1'b1;
          end
        end
        OP_LJ:  npc = {page, rv};
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rp  <= '0;
      sp  <= '0;
      err <= 1'b0;
      for (int i = 0; i < DEPTH; i++) stack[i] <= '0;
    end else begin
      rp  <= npc;
      err <= w_err;
      if (w_push) begin
        sp <= sp + SPW'(1);
        for (int i = 0; i < DEPTH; i++)
          if (sp == SPW'(i)) stack[i] <= w_inc;
      end
      if (w_pop) sp <= sp - SPW'(1);
      // Full-stack JSR: drop the oldest return address, newest goes on top.
      if (w_shift) begin
        for (int i = 0; i < DEPTH - 1; i++) stack[i] <= stack[i+1];
        stack[DEPTH-1] <= w_inc;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pc_return_stack.sv
`default_nettype none
// ============================================================================
// tb_pc_return_stack : directed self-checking bench for pc_return_stack
// Rev 1.0
// ============================================================================
module tb_pc_return_stack;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        hold;
  logic [2:0]  op;
  logic        cz;
  logic        csel;
  logic [9:0]  start_address;
  logic [9:0]  br_tgt;
  logic [9:0]  subroutine;
  logic [7:0]  rv;
  logic [1:0]  page;
  logic [9:0]  rp;
  logic [9:0]  npc;
  logic [2:0]  sp;
  logic        full;
  logic        empty;
  logic        err;

  int n_tests = 0;
  int n_fail  = 0;

  pc_return_stack #(.AW(10), .OW(8), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .hold(hold), .op(op),
    .cz(cz), .csel(csel), .start_address(start_address), .br_tgt(br_tgt),
    .subroutine(subroutine), .rv(rv), .page(page), .rp(rp), .npc(npc),
    .sp(sp), .full(full), .empty(empty), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // apply one op across a rising edge; sample at the following falling edge
  task automatic step(input logic [2:0] o);
    op = o;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic jsr(input logic [9:0] tgt);
    subroutine = tgt;
    step(3'd3);
  endtask

  task automatic lj(input logic [1:0] pg, input logic [7:0] lo);
    page = pg;
    rv   = lo;
    step(3'd5);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; hold = 1'b0; op = 3'd0; cz = 1'b0; csel = 1'b0;
    start_address = '0; br_tgt = '0; subroutine = '0; rv = '0; page = '0;
    repeat (2) @(negedge clk);
    check("rst_rp", rp, 0);
    check("rst_sp", sp, 0);
    check("rst_err", err, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    rst_n = 1'b1;

    // start wins over JSR
    start = 1'b1; start_address = 10'h100; subroutine = 10'h200;
    step(3'd3);
    start = 1'b0;
    check("start_rp", rp, 10'h100);
    check("start_sp", sp, 0);

    // REL taken with negative offset
    csel = 1'b1; cz = 1'b1; rv = 8'hF0; op = 3'd2;
    #1 check("rel_npc_comb", npc, 10'h0F0);
    step(3'd2);
    check("rel_rp", rp, 10'h0F0);
    // REL not taken
    cz = 1'b0;
    step(3'd2);
    check("rel_nt_rp", rp, 10'h0F1);

    lj(2'd3, 8'hFF);
    check("lj_3ff", rp, 10'h3FF);
    step(3'd0);
    check("inc_wrap", rp, 10'h000);
    step(3'd7);
    check("reserved_inc", rp, 10'h001);

    csel = 1'b1; cz = 1'b1; br_tgt = 10'h0CC;
    step(3'd1);
    check("br_taken", rp, 10'h0CC);
    csel = 1'b0;
    step(3'd1);
    check("br_not_taken", rp, 10'h0CD);
    lj(2'd2, 8'h2F);
    check("lj_22f", rp, 10'h22F);

    // nested calls
    lj(2'd0, 8'h10);
    jsr(10'h020); check("jsr1_rp", rp, 10'h020); check("jsr1_sp", sp, 1); check("jsr1_err", err, 0);
    jsr(10'h030); check("jsr2_rp", rp, 10'h030); check("jsr2_sp", sp, 2);
    jsr(10'h100); check("jsr3_rp", rp, 10'h100); check("jsr3_sp", sp, 3); check("jsr3_err", err, 0);
    step(3'd4); check("ret1_rp", rp, 10'h031); check("ret1_sp", sp, 2); check("ret1_err", err, 0);
    step(3'd4); check("ret2_rp", rp, 10'h021); check("ret2_sp", sp, 1);
    step(3'd4); check("ret3_rp", rp, 10'h011); check("ret3_sp", sp, 0); check("ret3_err", err, 0);

    // underflow
    step(3'd4);
    check("uflow_rp", rp, 10'h012); check("uflow_sp", sp, 0); check("uflow_err", err, 1);
    step(3'd0);
    check("uflow_err_clr", err, 0); check("uflow_inc", rp, 10'h013);

    // hold freezes everything
    hold = 1'b1; subroutine = 10'h2AA;
    step(3'd3);
    hold = 1'b0;
    check("hold_rp", rp, 10'h013); check("hold_sp", sp, 0); check("hold_err", err, 0);

    // overflow
    lj(2'd0, 8'h40);
    jsr(10'h050); jsr(10'h060); jsr(10'h070); jsr(10'h080);
    check("ovf_sp4", sp, 4); check("ovf_full", full, 1); check("ovf_err0", err, 0);
    jsr(10'h090);
    check("ovf_err", err, 1); check("ovf_sp", sp, 4);
`ifdef PC_STACK_TRAP_EN
    check("ovf_rp", rp, 10'h3FF);
    step(3'd4); check("ovf_err_clr", err, 0); check("ovr_ret1", rp, 10'h071);
    step(3'd4); check("ovr_ret2", rp, 10'h061);
    step(3'd4); check("ovr_ret3", rp, 10'h051);
    step(3'd4); check("ovr_ret4", rp, 10'h041);
`else
    check("ovf_rp", rp, 10'h090);
    step(3'd4); check("ovf_err_clr", err, 0); check("ovr_ret1", rp, 10'h081);
    step(3'd4); check("ovr_ret2", rp, 10'h071);
    step(3'd4); check("ovr_ret3", rp, 10'h061);
    step(3'd4); check("ovr_ret4", rp, 10'h051);
`endif
    check("ovr_sp0", sp, 0);

    // async reset mid-run during a JSR
    lj(2'd1, 8'h55);
    jsr(10'h0A0);
    check("pre_rst_sp", sp, 1);
    subroutine = 10'h0B0; op = 3'd3;
    #2 rst_n = 1'b0;
    #1 check("arst_rp", rp, 0);
    check("arst_sp", sp, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step(3'd0); check("post_rst_inc1", rp, 10'h001);
    step(3'd0); check("post_rst_inc2", rp, 10'h002);
    step(3'd4); check("post_rst_ret_err", err, 1); check("post_rst_ret_rp", rp, 10'h003);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
`default_nettype wire
